// File: rtl/mul_iter_unit.sv
// Iterative shift-add WIDTH x WIDTH multiplier with write-back handshake to the register file.
// Optional early termination on an exhausted multiplier: define MUL_EARLY_TERM_EN.
module mul_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       dst,
  input  logic             wb_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       res_dst,
  output logic             res_we,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [3:0] NO_REG = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    count_r;
  logic [3:0]       res_dst_r;
  logic             busy_r;
  logic             res_valid_r;
  logic             flag_n_r;
  logic             flag_z_r;

  logic [WIDTH-1:0] acc_step_s;
  logic [WIDTH-1:0] mcand_step_s;
  logic [WIDTH-1:0] mplier_step_s;
  logic             last_iter_s;

  // One shift-add step: conditionally add the multiplicand, wrap mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] add_step(
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] mcand,
    input logic             take
  );
    logic [WIDTH-1:0] sum;
    if (take) begin
      sum = acc + mcand;
    end else begin
      sum = acc;
    end
    return sum;
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == ZERO_W);
  endfunction

  // Next-iteration datapath values and the termination decision for RUN.
  always_comb begin
    acc_step_s    = add_step(acc_r, mcand_r, mplier_r[0]);
    mcand_step_s  = mcand_r << 1;
    mplier_step_s = mplier_r >> 1;
`ifdef MUL_EARLY_TERM_EN
    last_iter_s   = (count_r == LAST_CNT) || is_zero(mplier_step_s);
`else
    last_iter_s   = (count_r == LAST_CNT);
`endif
  end

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= ZERO_W;
      mcand_r     <= ZERO_W;
      mplier_r    <= ZERO_W;
      count_r     <= ZERO_CNT;
      res_dst_r   <= 4'h0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      flag_n_r    <= 1'b0;
      flag_z_r    <= 1'b1;
    end else if (flush) begin
      // Abort wins over start and wb_ready; the partial product is discarded.
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r     <= ZERO_W;
            mcand_r   <= srca;
            mplier_r  <= srcb;
            res_dst_r <= dst;
            count_r   <= ZERO_CNT;
            flag_n_r  <= 1'b0;
            flag_z_r  <= 1'b1;
            busy_r    <= 1'b1;
            if (is_zero(srcb)) begin
              state_r     <= DONE;
              res_valid_r <= 1'b1;
            end else begin
              state_r     <= RUN;
              res_valid_r <= 1'b0;
            end
          end else begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
          end
        end
        RUN: begin
          acc_r    <= acc_step_s;
          mcand_r  <= mcand_step_s;
          mplier_r <= mplier_step_s;
          count_r  <= count_r + ONE_CNT;
          flag_n_r <= acc_step_s[WIDTH-1];
          flag_z_r <= is_zero(acc_step_s);
          busy_r   <= 1'b1;
          if (last_iter_s) begin
            state_r     <= DONE;
            res_valid_r <= 1'b1;
          end else begin
            state_r     <= RUN;
            res_valid_r <= 1'b0;
          end
        end
        DONE: begin
          if (wb_ready) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
          end else begin
            state_r     <= DONE;
            busy_r      <= 1'b1;
            res_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign result    = acc_r;
  assign res_dst   = res_dst_r;
  assign flag_n    = flag_n_r;
  assign flag_z    = flag_z_r;
  // R15 has no storage, so its write is suppressed while the handshake still retires.
  assign res_we    = res_valid_r & wb_ready & ~flush & (res_dst_r != NO_REG);

endmodule

// File: doc/mul_iter_unit.md
Name: mul_iter_unit

Overview:
- Iterative shift-add 32x32 multiplier in the execute stage, directly downstream of the three-ported register file.
- Consumes the two register-file read operands (rd1 to srca, rd2 to srcb) and a destination register index.
- Produces the low WIDTH bits of the product plus N/Z flags.
- Presents a write-back request (value, index, enable) that drives the register-file write port, with a valid/ready handshake so the pipeline can stall.

Parameters:
- WIDTH, 32, operand/result width; legal range 4..32; iteration counter width is clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- flush  input  1  abort current operation, discard result
- srca  input  WIDTH  multiplicand (register-file rd1)
- srcb  input  WIDTH  multiplier (register-file rd2)
- dst  input  4  destination register index, captured with start
- wb_ready  input  1  write-back slot available this cycle
- busy  output  1  high in RUN or DONE; upstream must not issue start
- res_valid  output  1  result held and valid (state DONE)
- result  output  WIDTH  product, low WIDTH bits
- res_dst  output  4  captured dst
- res_we  output  1  register-file write enable = res_valid & wb_ready & (res_dst != 4'hF)
- flag_n  output  1  result[WIDTH-1], valid with res_valid
- flag_z  output  1  result == 0, valid with res_valid

Behaviour:
- Reset (async, any state): state=IDLE; acc, mcand, mplier, count, res_dst cleared; busy=0, res_valid=0, res_we=0, result=0, flag_n=0, flag_z=1.
- FSM states IDLE, RUN, DONE.
  - IDLE:
    - start & !flush: capture acc=0, mcand=srca, mplier=srcb, res_dst=dst, count=0, then go to RUN.
    - start with srcb==0: go directly to DONE with acc=0.
    - flush in IDLE: start ignored that cycle; stay IDLE.
  - RUN, each cycle:
    - If mplier[0], acc += mcand (mod 2^WIDTH).
    - mcand <<= 1; mplier >>= 1; count += 1.
    - Go to DONE on the edge where count==WIDTH-1 (base build).
  - DONE: hold result/res_dst/flags stable.
    - wb_ready=1: res_we pulses (unless res_dst==15) and the next state is IDLE.
    - wb_ready=0: stay in DONE indefinitely.
- Latency, base build, start sampled at end of cycle N:
  - srcb!=0: res_valid high from cycle N+1+WIDTH (N+33 for WIDTH=32).
  - srcb==0: res_valid high from cycle N+1.
- Back-to-back: start is not accepted in the cycle DONE is consumed; the next accept is earliest in the following IDLE cycle.
- flush in RUN or DONE: next state IDLE, res_valid drops, no res_we that cycle. flush overrides wb_ready.
- dst==15: the multiply completes and the handshake retires normally, but res_we stays 0. The register file has no R15 storage.
- Only the low WIDTH bits are produced, so signed and unsigned operands yield identical bits.
- result and flags are driven from acc; they are meaningful only while res_valid=1.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined: in RUN, transition to DONE on the edge where the post-shift mplier is zero or count==WIDTH-1, whichever comes first.
  - If k is the highest set bit of srcb, res_valid rises at cycle N+k+2.
  - srcb==0 still completes at N+1.
- Undefined: fixed WIDTH iterations as in Behaviour. Results are bit-identical in both builds; only latency differs.

Test Plan:
- srca=7, srcb=6, dst=3, wb_ready=1: result=42, flag_n=0, flag_z=0, res_we pulses once with res_dst=3. Timing: cycle N+33 in base build, N+4 with MUL_EARLY_TERM_EN.
- srca=0xFFFFFFFF, srcb=0xFFFFFFFF: result=0x00000001 at N+33 in both builds. srca=0x80000000, srcb=1: result=0x80000000, flag_n=1.
- srca=0x1234, srcb=0: res_valid at N+1, result=0, flag_z=1.
- Backpressure: wb_ready low 5 cycles after res_valid rises. result/res_dst held constant and res_we=0 for those cycles; one res_we pulse when wb_ready rises; busy falls the next cycle.
- Aborts:
  - flush asserted in RUN cycle 10: IDLE next cycle, no res_valid/res_we ever produced for that operation.
  - reset asserted asynchronously mid-RUN: all outputs reach reset values immediately, without waiting for a clock edge.
  - start with dst=15, srca=3, srcb=5: result=15 and handshake completes, but res_we stays 0.
